// File: rtl/mem8x8_pkg.sv
// Shared definitions for masters of the 8x8 byte memory.
// Holds the address/data widths, the strobe counter width, the FSM state
// encoding used by ram_master and a helper that computes the counter reload.
package mem8x8_pkg;

  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned DATA_W     = 8;
  // Down-counter only ever holds STROBE_CYCLES-1, so 2 bits cover 1..4.
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned STROBE_MAX = 4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSetup  = 3'd1,
    StStrobe = 3'd2,
    StHold   = 3'd3,
    StResp   = 3'd4
  } state_e;

  // Value loaded into the strobe down-counter on entry to StStrobe.
  function automatic logic [CNT_W-1:0] strobe_load(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/ram_master_if.sv
// Request/response and memory-side signal bundle for ram_master.
//   req_*  : requester -> master access request (valid/ready handshake)
//   rsp_*  : master -> requester read response (valid/ready handshake)
//   ram_*  : master <-> 8x8 memory strobe interface
// Modports:
//   master : the view of ram_master itself
//   slave  : the view of the environment (requester plus memory)
interface ram_master_if;
  import mem8x8_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  logic [DATA_W-1:0] ram_inp;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_op;
  logic              ram_sel;
  logic [DATA_W-1:0] ram_outp;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  rsp_ready,
    input  ram_outp,
    output req_ready,
    output rsp_valid, rsp_rdata,
    output ram_inp, ram_addr, ram_op, ram_sel
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output rsp_ready,
    output ram_outp,
    input  req_ready,
    input  rsp_valid, rsp_rdata,
    input  ram_inp, ram_addr, ram_op, ram_sel
  );

endinterface

// File: rtl/ram_master.sv
// Single-access master for an 8x8 byte memory with a select strobe.
// Each accepted request walks Idle -> Setup -> Strobe (STROBE_CYCLES cycles)
// -> Hold, then writes return to Idle and reads present their data in Resp
// until the requester takes it.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ram_master_if.master (request, response and memory signals)
// Parameters:
//   STROBE_CYCLES : cycles ram_sel is held high per access, legal 1..4
module ram_master
  import mem8x8_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 1
) (
  input logic          clk,
  input logic          rst_n,
  ram_master_if.master bus
);

  if ((STROBE_CYCLES < 1) || (STROBE_CYCLES > STROBE_MAX)) begin : gen_bad_strobe
    $error("ram_master: STROBE_CYCLES must be in 1..4");
  end

  localparam logic [CNT_W-1:0] StrobeLoad = strobe_load(STROBE_CYCLES);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ram_sel_q;
  logic              ram_op_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_inp_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  // Address/data/op are only loaded on acceptance, so they stay frozen for the
  // whole access and keep their last value while idle or responding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ram_sel_q   <= 1'b0;
      ram_op_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_inp_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            ram_op_q   <= bus.req_write;
            ram_addr_q <= bus.req_addr;
            ram_inp_q  <= bus.req_wdata;
            state_q    <= StSetup;
          end
        end
        StSetup: begin
          ram_sel_q <= 1'b1;
          cnt_q     <= StrobeLoad;
          state_q   <= StStrobe;
        end
        StStrobe: begin
          if (cnt_q == '0) begin
            ram_sel_q <= 1'b0;
            state_q   <= StHold;
            // Sample memory data on the edge that closes the strobe.
            if (!ram_op_q) begin
              rsp_rdata_q <= bus.ram_outp;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHold: begin
          if (ram_op_q) begin
            state_q <= StIdle;
          end else begin
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          // Unused encodings recover to a quiet idle.
          ram_sel_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  // req_ready is decoded from the registered state; reset forces Idle, so it
  // is also high throughout reset.
  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.ram_inp   = ram_inp_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_op    = ram_op_q;
  assign bus.ram_sel   = ram_sel_q;

endmodule

// File: tb/tb_ram_master.sv
// Randomised self-checking bench for ram_master. Two instances run side by
// side (STROBE_CYCLES 1 and 3), each with a behavioural 8x8 memory. Expected
// read data comes from a reference array updated from the issued writes;
// timing expectations come from the cycle counts of each access type.
module tb_ram_master;
  import mem8x8_pkg::*;

  localparam int unsigned Sc0 = 1;
  localparam int unsigned Sc1 = 3;

  typedef struct packed {
    logic       req_ready;
    logic       rsp_valid;
    logic       ram_sel;
    logic       ram_op;
    logic [2:0] ram_addr;
    logic [7:0] ram_inp;
    logic [7:0] rsp_rdata;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n_v;
  logic [1:0] req_valid_v;
  logic [1:0] req_write_v;
  logic [1:0] rsp_ready_v;
  logic [2:0] req_addr_v  [2];
  logic [7:0] req_wdata_v [2];

  logic [7:0] mem      [2][8];
  logic [7:0] init_val [2][8];
  logic [7:0] ref_mem  [2][8];
  logic [7:0] last_rdata [2];
  logic       mem_init_en;

  int n_checks = 0;
  int n_errors = 0;

  ram_master_if bus0 ();
  ram_master_if bus1 ();

  ram_master #(.STROBE_CYCLES(Sc0)) u_dut0 (.clk(clk), .rst_n(rst_n_v[0]), .bus(bus0));
  ram_master #(.STROBE_CYCLES(Sc1)) u_dut1 (.clk(clk), .rst_n(rst_n_v[1]), .bus(bus1));

  assign bus0.req_valid = req_valid_v[0];
  assign bus0.req_write = req_write_v[0];
  assign bus0.req_addr  = req_addr_v[0];
  assign bus0.req_wdata = req_wdata_v[0];
  assign bus0.rsp_ready = rsp_ready_v[0];
  assign bus1.req_valid = req_valid_v[1];
  assign bus1.req_write = req_write_v[1];
  assign bus1.req_addr  = req_addr_v[1];
  assign bus1.req_wdata = req_wdata_v[1];
  assign bus1.rsp_ready = rsp_ready_v[1];

  // Behavioural memories: asynchronous read, write on each strobed edge.
  always @(posedge clk) begin
    if (mem_init_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[0][i] <= init_val[0][i];
        mem[1][i] <= init_val[1][i];
      end
    end else begin
      if (bus0.ram_sel && bus0.ram_op) mem[0][bus0.ram_addr] <= bus0.ram_inp;
      if (bus1.ram_sel && bus1.ram_op) mem[1][bus1.ram_addr] <= bus1.ram_inp;
    end
  end
  assign bus0.ram_outp = mem[0][bus0.ram_addr];
  assign bus1.ram_outp = mem[1][bus1.ram_addr];

  obs_t obs0, obs1;
  assign obs0 = {bus0.req_ready, bus0.rsp_valid, bus0.ram_sel, bus0.ram_op,
                 bus0.ram_addr, bus0.ram_inp, bus0.rsp_rdata};
  assign obs1 = {bus1.req_ready, bus1.rsp_valid, bus1.ram_sel, bus1.ram_op,
                 bus1.ram_addr, bus1.ram_inp, bus1.rsp_rdata};

  function automatic obs_t sample(input int d);
    return (d == 1) ? obs1 : obs0;
  endfunction

  function automatic int sc_of(input int d);
    return (d == 1) ? int'(Sc1) : int'(Sc0);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_values(input int d, input string pfx);
    obs_t o;
    o = sample(d);
    check_eq($sformatf("%s_d%0d_ready", pfx, d), 32'(o.req_ready), 32'd1);
    check_eq($sformatf("%s_d%0d_sel", pfx, d), 32'(o.ram_sel), 32'd0);
    check_eq($sformatf("%s_d%0d_rsp_valid", pfx, d), 32'(o.rsp_valid), 32'd0);
    check_eq($sformatf("%s_d%0d_ram_bus", pfx, d),
             32'({o.ram_op, o.ram_addr, o.ram_inp}), 32'd0);
    check_eq($sformatf("%s_d%0d_rdata", pfx, d), 32'(o.rsp_rdata), 32'd0);
  endtask

  // One access, entered and left at a negedge. With hold_valid the request
  // line stays high while busy (carrying junk that must be ignored) and the
  // caller must present its next request or drop valid without delay.
  task automatic access(input int d, input bit wr, input logic [2:0] a, input logic [7:0] wd,
                        input int dly, input bit hold_valid);
    obs_t       o;
    int         waits, sel_n, first_sel, bad_bus, bad_rsp, rsp_seen, occ;
    bit         done;
    logic [7:0] exp_rd, got_rd;
    req_write_v[d] = wr;
    req_addr_v[d]  = a;
    req_wdata_v[d] = wd;
    req_valid_v[d] = 1'b1;
    waits = 0;
    while (!sample(d).req_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!sample(d).req_ready) begin
      check_eq($sformatf("d%0d_accept_timeout", d), 32'd0, 32'd1);
      req_valid_v[d] = 1'b0;
      return;
    end
    exp_rd = ref_mem[d][a];
    if (wr) ref_mem[d][a] = wd;
    @(negedge clk);
    if (hold_valid) begin
      req_write_v[d] = 1'($urandom);
      req_addr_v[d]  = 3'($urandom);
      req_wdata_v[d] = 8'($urandom);
    end else begin
      req_valid_v[d] = 1'b0;
    end
    sel_n = 0; first_sel = 0; bad_bus = 0; bad_rsp = 0; rsp_seen = 0; occ = -1;
    got_rd = 8'h00; done = 1'b0;
    for (int k = 1; k <= 60 && !done; k++) begin
      o = sample(d);
      if (o.req_ready) begin
        done = 1'b1;
        occ  = k - 1;
      end else begin
        if (o.ram_sel) begin
          sel_n++;
          if (first_sel == 0) first_sel = k;
        end
        if (o.ram_addr !== a || o.ram_op !== wr || o.ram_inp !== wd) bad_bus++;
        if (o.rsp_valid) begin
          rsp_seen++;
          if (rsp_seen == 1) got_rd = o.rsp_rdata;
          else if (o.rsp_rdata !== got_rd) bad_rsp++;
          rsp_ready_v[d] = (rsp_seen > dly);
        end else begin
          rsp_ready_v[d] = 1'($urandom);
        end
        @(negedge clk);
      end
    end
    if (!done) check_eq($sformatf("d%0d_busy_timeout", d), 32'd0, 32'd1);
    check_eq($sformatf("d%0d_sel_cycles", d), 32'(sel_n), 32'(sc_of(d)));
    check_eq($sformatf("d%0d_sel_start", d), 32'(first_sel), 32'd2);
    check_eq($sformatf("d%0d_ram_bus_stable", d), 32'(bad_bus), 32'd0);
    if (wr) begin
      check_eq($sformatf("d%0d_wr_occupancy", d), 32'(occ), 32'(sc_of(d) + 2));
      check_eq($sformatf("d%0d_wr_no_rsp", d), 32'(rsp_seen), 32'd0);
    end else begin
      check_eq($sformatf("d%0d_rd_occupancy", d), 32'(occ), 32'(sc_of(d) + 3 + dly));
      check_eq($sformatf("d%0d_rsp_cycles", d), 32'(rsp_seen), 32'(dly + 1));
      check_eq($sformatf("d%0d_rdata_a%0d", d, a), 32'(got_rd), 32'(exp_rd));
      check_eq($sformatf("d%0d_rdata_stable", d), 32'(bad_rsp), 32'd0);
      last_rdata[d] = exp_rd;
    end
    o = sample(d);
    check_eq($sformatf("d%0d_rsp_fall", d), 32'(o.rsp_valid), 32'd0);
    check_eq($sformatf("d%0d_rdata_kept", d), 32'(o.rsp_rdata), 32'(last_rdata[d]));
  endtask

  task automatic reset_mid_strobe(input int d);
    int waits, bad_valid, not_ready;
    req_write_v[d] = 1'b0;
    req_addr_v[d]  = 3'($urandom);
    req_wdata_v[d] = 8'($urandom);
    req_valid_v[d] = 1'b1;
    rsp_ready_v[d] = 1'b0;
    @(negedge clk);
    req_valid_v[d] = 1'b0;
    waits = 0;
    while (!sample(d).ram_sel && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check_eq($sformatf("d%0d_rst_reach_strobe", d), 32'(sample(d).ram_sel), 32'd1);
    #2 rst_n_v[d] = 1'b0;
    #1;
    check_reset_values(d, "midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n_v[d] = 1'b1;
    last_rdata[d] = 8'h00;
    bad_valid = 0; not_ready = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rsp_ready_v[d] = 1'($urandom);
      if (sample(d).rsp_valid) bad_valid++;
      if (!sample(d).req_ready) not_ready++;
    end
    check_eq($sformatf("d%0d_rst_no_rsp", d), 32'(bad_valid), 32'd0);
    check_eq($sformatf("d%0d_rst_ready", d), 32'(not_ready), 32'd0);
  endtask

  initial begin
    rst_n_v     = 2'b00;
    req_valid_v = 2'b00;
    req_write_v = 2'b00;
    rsp_ready_v = 2'b00;
    for (int d = 0; d < 2; d++) begin
      req_addr_v[d]  = 3'd0;
      req_wdata_v[d] = 8'd0;
      last_rdata[d]  = 8'h00;
      for (int i = 0; i < 8; i++) begin
        init_val[d][i] = 8'($urandom);
        ref_mem[d][i]  = init_val[d][i];
      end
    end
    mem_init_en = 1'b1;
    repeat (2) @(negedge clk);
    mem_init_en = 1'b0;
    check_reset_values(0, "por");
    check_reset_values(1, "por");
    rst_n_v = 2'b11;
    @(negedge clk);
    check_reset_values(0, "post_rst");

    // Write then read back, read-modify-read, slow response.
    access(0, 1'b1, 3'd1, 8'hAA, 0, 1'b0);
    access(0, 1'b0, 3'd1, 8'($urandom), 0, 1'b0);
    access(0, 1'b0, 3'd2, 8'($urandom), 0, 1'b0);
    access(0, 1'b1, 3'd2, 8'hAB, 0, 1'b0);
    access(0, 1'b0, 3'd2, 8'($urandom), 0, 1'b0);
    access(0, 1'b0, 3'd3, 8'($urandom), 5, 1'b0);
    access(1, 1'b1, 3'd7, 8'h5C, 0, 1'b0);
    access(1, 1'b0, 3'd7, 8'($urandom), 5, 1'b0);

    // Back-to-back writes with valid held high, then a read sweep.
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 8; a++) access(d, 1'b1, 3'(a), 8'($urandom), 0, 1'b1);
      req_valid_v[d] = 1'b0;
      for (int a = 0; a < 8; a++) access(d, 1'b0, 3'(a), 8'($urandom), int'($urandom_range(0, 2)), 1'b0);
    end

    // Random mix of reads/writes, response delays and held requests.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 40; n++) begin
        access(d, 1'($urandom), 3'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
               1'($urandom));
      end
      req_valid_v[d] = 1'b0;
      @(negedge clk);
    end

    // Reset in the middle of a read strobe, then confirm normal service.
    for (int d = 0; d < 2; d++) begin
      reset_mid_strobe(d);
      access(d, 1'b0, 3'($urandom), 8'($urandom), 1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
